// File: rtl/ws2812b_rx.sv
// ws2812b_rx: single-wire WS2812B stream receiver.
// Classifies high pulses on din as 0/1 bits and assembles 24-bit GRB pixels.
// Pixel 0 of each frame is kept as own_color. Later pixels go out on dout.
module ws2812b_rx #(
  parameter int T_MIN_HIGH   = 8,
  parameter int T_BIT_THRESH = 38,
  parameter int T_HIGH_MAX   = 160,
  parameter int T_RESET      = 3200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        err_clr,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [5:0]  pixel_index,
  output logic [23:0] own_color,
  output logic        frame_done,
  output logic        dout,
  output logic        err
);

  localparam int LW = $clog2(T_RESET + 1);

  localparam logic [LW-1:0] L_GAP    = LW'(T_RESET);
  localparam logic [LW-1:0] L_GAP_M1 = LW'(T_RESET - 1);
  localparam logic [7:0]    H_MIN    = 8'(T_MIN_HIGH);
  localparam logic [7:0]    H_ONE    = 8'(T_BIT_THRESH);
  localparam logic [7:0]    H_MAX    = 8'(T_HIGH_MAX);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic          din_m;
  logic          din_s;
  logic [7:0]    hcnt;
  logic [LW-1:0] lcnt;
  logic [1:0]    state;
  logic [22:0]   shift;
  logic [4:0]    bit_cnt;
  logic [5:0]    pix_cnt;
  logic          fwd;
  logic          any_bit;

  logic          gap_hit;
  logic          bit_val;
  logic          err_ev;

  // Two-flop synchroniser for the asynchronous input pin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  // High/low run-length counters, each cleared by the opposite level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      lcnt <= '0;
    end else if (din_s) begin
      hcnt <= (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
      lcnt <= '0;
    end else begin
      hcnt <= '0;
      lcnt <= (lcnt == L_GAP) ? lcnt : lcnt + LW'(1);
    end
  end

  // Gap strobe fires only on the cycle lcnt steps onto T_RESET, so a long low fires once
  always_comb begin
    gap_hit = !din_s && (lcnt == L_GAP_M1);
    bit_val = (hcnt >= H_ONE);
    err_ev  = 1'b0;
    if (state == S_HIGH && !din_s && hcnt < H_MIN)
      err_ev = 1'b1;
    if (state == S_HIGH && din_s && hcnt > H_MAX)
      err_ev = 1'b1;
    if (state == S_LOW && gap_hit && bit_cnt != 5'd0)
      err_ev = 1'b1;
  end

  // Receive FSM, bit/pixel assembly, frame bookkeeping and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_SYNC;
      shift       <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      fwd         <= 1'b0;
      any_bit     <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      own_color   <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= err_ev | (err & ~err_clr);
      case (state)
        S_SYNC: begin
          // Recovery gap only re-arms reception; nothing was accepted, so no frame_done
          if (gap_hit) begin
            state   <= S_LOW;
            bit_cnt <= '0;
            pix_cnt <= '0;
            fwd     <= 1'b0;
            any_bit <= 1'b0;
          end
        end
        S_LOW: begin
          if (din_s) begin
            state <= S_HIGH;
          end else if (gap_hit) begin
            frame_done <= any_bit;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            fwd        <= 1'b0;
            any_bit    <= 1'b0;
          end
        end
        S_HIGH: begin
          if (!din_s) begin
            state <= S_LOW;
            if (hcnt >= H_MIN) begin
              any_bit <= 1'b1;
              if (bit_cnt == 5'd23) begin
                pixel_data  <= {shift, bit_val};
                pixel_valid <= 1'b1;
                pixel_index <= pix_cnt;
                pix_cnt     <= (pix_cnt == 6'd63) ? pix_cnt : pix_cnt + 6'd1;
                bit_cnt     <= '0;
                if (pix_cnt == 6'd0) begin
                  own_color <= {shift, bit_val};
                  fwd       <= 1'b1;
                end
              end else begin
                shift   <= {shift[21:0], bit_val};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else if (hcnt > H_MAX) begin
            state   <= S_SYNC;
            bit_cnt <= '0;
            fwd     <= 1'b0;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

  // Forwarded stream: gated, registered copy of the synchronised input
  always_ff @(posedge clk) begin
    if (!rst_n) dout <= 1'b0;
    else        dout <= fwd & din_s;
  end

endmodule

// File: doc/ws2812b_rx.md
# ws2812b_rx

Single-wire WS2812B stream receiver: the device end of the protocol the TinyQV WS2812B driver transmits. It samples an input pin and classifies each high pulse as a 0 or 1 bit. It assembles 24-bit GRB pixels, detects the ≥50 µs reset gap, and captures the first pixel of each frame as its own colour. Like a real WS2812B, it forwards all later pixels on `dout` to the next device in the chain. It sits behind a peripheral register wrapper, with `din` taken from `ui_in` and `dout` driven onto `uo_out`.

## Interface

Parameters (cycle counts assume a 64 MHz clock):

- `T_MIN_HIGH`, default 8: high pulses shorter than this are glitches.
- `T_BIT_THRESH`, default 38: a high pulse of at least this many cycles is a 1, otherwise a 0.
- `T_HIGH_MAX`, default 160: a high pulse longer than this is a stuck-high error.
- `T_RESET`, default 3200: continuous low cycles that constitute a reset/latch gap (50 µs).

Ports (clock and reset first):

- `clk` in 1: clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous, active-low reset.
- `din` in 1: asynchronous serial input.
- `err_clr` in 1: clears `err` for one cycle.
- `pixel_data` out 24: last complete pixel, GRB order, G[7] first on the wire; held until the next pixel.
- `pixel_valid` out 1: one-cycle pulse when `pixel_data` updates.
- `pixel_index` out 6: frame index of `pixel_data`; saturates at 63.
- `own_color` out 24: pixel 0 of the most recent frame.
- `frame_done` out 1: one-cycle pulse on a reset gap after ≥1 bit.
- `dout` out 1: forwarded stream to the downstream device.
- `err` out 1: sticky error flag.

## Operation

- Input synchronisation: `din` passes through a 2-flop synchroniser to give `din_s`. All logic uses `din_s`.
- Counters:
  - `hcnt` is 8 bits and saturating; it counts cycles with `din_s`=1.
  - `lcnt` counts cycles with `din_s`=0; it is `$clog2(T_RESET+1)` bits wide and saturates at `T_RESET`.
  - Each counter clears on the opposite level.
- FSM states: SYNC, LOW, HIGH.
  - SYNC: entered from reset and on stuck-high. No bits are accepted. When `lcnt` reaches `T_RESET`, go to LOW.
  - LOW: on `din_s`=1, go to HIGH. If `lcnt` reaches `T_RESET`, perform a reset gap and stay in LOW.
  - HIGH:
    - On `din_s`=0, classify the pulse using `hcnt` and go to LOW.
    - If `hcnt` exceeds `T_HIGH_MAX`, set `err`, clear `bit_cnt`/`fwd`, and go to SYNC.
- Classification on a falling edge in HIGH:
  - If `hcnt` < `T_MIN_HIGH`: set `err`, no bit.
  - Otherwise, bit = (`hcnt` ≥ `T_BIT_THRESH`).
  - The bit shifts into the 23-bit shift register MSB-first, and `bit_cnt` (0..23) increments.
- 24th bit:
  - `pixel_data` ← {shift, bit}; pulse `pixel_valid`.
  - `pixel_index` ← `pix_cnt`, then `pix_cnt` increments, saturating at 63.
  - If `pix_cnt` was 0: `own_color` ← the pixel and `fwd` ← 1.
  - `bit_cnt` ← 0.
- Reset gap:
  - If `bit_cnt`≠0, set `err` and discard the partial pixel.
  - If any bit was received since the last gap, pulse `frame_done`.
  - Clear `bit_cnt`, `pix_cnt` and `fwd`.
  - `frame_done` fires once per gap; a continuing low does not re-fire it.
- Forwarding: `dout` ← registered (`fwd` & `din_s`).
  - `fwd` sets only on a falling edge, so the forwarded stream never starts mid-pulse.
  - Pixel 0 is never forwarded.
- Error flag:
  - `err` is cleared by `err_clr`.
  - If an error event and `err_clr` occur in the same cycle, set wins.
- Reset (`rst_n`=0): all outputs, counters, `fwd` and shift register go to 0; state → SYNC. This also applies mid-frame; no pulse is generated.

## Timing

- Reset values: `pixel_data`=0, `pixel_valid`=0, `pixel_index`=0, `own_color`=0, `frame_done`=0, `dout`=0, `err`=0.
- Pin-to-logic latency: 2 cycles.
- `pixel_valid` rises 3 clock edges after the first edge that samples the 24th bit's falling edge on `din`. `pixel_data`, `pixel_index` and `own_color` are valid in that same cycle.
- `dout` lags `din` by 3 cycles; pulse widths are preserved exactly.
- `frame_done` pulses 3 cycles after `lcnt` would reach `T_RESET` counted from the pin.
- There is no backpressure. Pixels arrive ≥24×(min bit period) apart; the consumer must sample each `pixel_valid` pulse.

## Test plan

- After reset: hold `din`=0 for 3200 cycles, then send `0x112233` as 24 bits. Encoding: 0 = 26 high / 54 low, 1 = 51 high / 29 low.
  - Required: `pixel_valid` pulses once; `pixel_data`=`own_color`=0x112233; `pixel_index`=0; `dout` stays 0.
- Send 3 pixels `0xFF0000`, `0x00FF00`, `0x0000FF`, then 3200 low.
  - Required: 3 `pixel_valid` pulses with `pixel_index` 0,1,2; `own_color`=0xFF0000.
  - `dout` reproduces pixels 1–2 bit-exactly, 3 cycles late.
  - One `frame_done` pulse; `err`=0.
- Bits arriving before any initial 3200-cycle low gap after reset: no `pixel_valid` and no `err` until the first gap completes.
- 12 bits then a gap: `err`=1, `frame_done` pulses, no `pixel_valid`. Then the next full pixel gives `pixel_index`=0.
- A 4-cycle glitch pulse sets `err` with no bit counted. `err_clr` clears it. An error in the same cycle as `err_clr` leaves `err`=1.
- `din` high for 200 cycles mid-pixel: `err`=1 and state SYNC. Bits are ignored until 3200 low cycles, and `rst_n` mid-frame zeroes all outputs.
